// File: rtl/fpu_issue_sched.sv
// Issue scheduler for the multi-cycle FPU: forwards integer ops, launches and times one FP op
// at a time, writes its result slot back and stalls upstream on hazards with the pending FP rd.
module fpu_issue_sched #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_aorf,
  input  logic [3:0]       in_aluop,
  input  logic             in_regwrite,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rdist,
  output logic             fpu_start,
  output logic [3:0]       fpu_op,
  output logic             fpu_abort,
  input  logic             fpu_valid,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] last_lat
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       pend_rd;
  logic             pend_we;
  logic             hazard;
  logic             accept_fp;
  logic             kill;
  logic             wait_done;
  logic             wait_timeout;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Handshake, hazard detection, Moore outputs and next-state selection; flush outranks
  // both result return and timeout while an FP op is in flight.
  always_comb begin
    busy         = (state != IDLE);
    hazard       = busy & pend_we & (pend_rd != 5'd0) &
                   ((in_rs == pend_rd) | (in_rt == pend_rd) |
                    (in_regwrite & (in_rdist == pend_rd)));
    in_ready     = !reset & !flush & !hazard & (!in_aorf | (state == IDLE));
    accept_fp    = in_valid & in_ready & in_aorf;
    kill         = flush & ((state == ISSUE) | (state == WAIT));
    fpu_start    = (state == ISSUE);
    wb_valid     = (state == DONE) & pend_we & !flush;
    wb_rd        = (state == DONE) ? pend_rd : 5'd0;
    wait_done    = 1'b0;
    wait_timeout = 1'b0;
    state_next   = state;
    case (state)
      IDLE:  if (accept_fp) state_next = ISSUE;
      ISSUE: state_next = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush) begin
          state_next = IDLE;
        end else if (fpu_valid) begin
          wait_done  = 1'b1;
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          wait_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
      DONE:  state_next = IDLE;
    endcase
  end

  // Pending-op bookkeeping, latency counter and the registered abort / error flags.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      pend_rd     <= 5'd0;
      pend_we     <= 1'b0;
      fpu_op      <= 4'd0;
      fpu_abort   <= 1'b0;
      timeout_err <= 1'b0;
      last_lat    <= '0;
    end else begin
      fpu_abort <= kill | wait_timeout;
      if (accept_fp) begin
        fpu_op  <= in_aluop;
        pend_rd <= in_rdist;
        pend_we <= in_regwrite;
      end else if (flush & busy) begin
        pend_we <= 1'b0;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (wait_done)    last_lat    <= cnt + 1'b1;
      if (wait_timeout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed bench for fpu_issue_sched: one task per scenario, each with hand-computed
// expectations, run in sequence from a single initial block.
module tb_fpu_issue_sched;

  localparam int CNT_W = 7;

  logic             CLK;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_aorf;
  logic [3:0]       in_aluop;
  logic             in_regwrite;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rdist;
  logic             fpu_start;
  logic [3:0]       fpu_op;
  logic             fpu_abort;
  logic             fpu_valid;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] last_lat;

  int checks = 0;
  int fails  = 0;

  fpu_issue_sched #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aorf(in_aorf), .in_aluop(in_aluop),
    .in_regwrite(in_regwrite), .in_rs(in_rs), .in_rt(in_rt), .in_rdist(in_rdist),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_abort(fpu_abort), .fpu_valid(fpu_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy), .timeout_err(timeout_err),
    .last_lat(last_lat)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_aorf = 0; in_aluop = 0; in_regwrite = 0;
    in_rs = 0; in_rt = 0; in_rdist = 0; fpu_valid = 0; flush = 0;
  endtask

  // Presents one FP op in IDLE and drives fpu_valid lat cycles after fpu_start; records
  // what the DUT did until busy drops (bounded at 40 cycles).
  task automatic run_fp_op(input logic [4:0] rd, input logic [3:0] op, input int lat,
                           output logic accepted, output int busy_cyc, output int start_cyc,
                           output int wb_cyc, output logic [4:0] wb_rd_seen,
                           output logic [3:0] op_seen);
    busy_cyc = 0; start_cyc = 0; wb_cyc = 0; wb_rd_seen = 0; op_seen = 0;
    in_valid = 1; in_aorf = 1; in_aluop = op; in_regwrite = 1; in_rdist = rd;
    in_rs = 0; in_rt = 0;
    #1 accepted = in_ready;
    tick();
    in_valid = 0; in_aorf = 0;
    for (int k = 0; k < 40; k++) begin
      fpu_valid = (k == lat);
      #1;
      if (busy) busy_cyc++;
      if (fpu_start) begin start_cyc++; op_seen = fpu_op; end
      if (wb_valid) begin wb_cyc++; wb_rd_seen = wb_rd; end
      if (!busy) break;
      tick();
    end
    fpu_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    in_valid = 1;
    #2;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_in_ready: got %0d expected 0", in_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %0d expected 0", busy); end
    checks++; if (fpu_start !== 1'b0) begin fails++; $display("[TB] FAIL rst_fpu_start: got %0d expected 0", fpu_start); end
    checks++; if (fpu_abort !== 1'b0) begin fails++; $display("[TB] FAIL rst_fpu_abort: got %0d expected 0", fpu_abort); end
    checks++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0) begin fails++; $display("[TB] FAIL rst_wb: got valid=%0d rd=%0d expected 0/0", wb_valid, wb_rd); end
    checks++; if (timeout_err !== 1'b0 || last_lat !== 7'd0 || fpu_op !== 4'd0) begin fails++; $display("[TB] FAIL rst_regs: got err=%0d lat=%0d op=%0d expected 0/0/0", timeout_err, last_lat, fpu_op); end
    tick();
    tick();
    reset = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_release_ready: got %0d expected 1", in_ready); end
    in_valid = 0;
  endtask

  task automatic test_basic();
    logic acc; int bc, sc, wc; logic [4:0] rds; logic [3:0] ops;
    run_fp_op(5'd5, 4'hA, 3, acc, bc, sc, wc, rds, ops);
    checks++; if (acc !== 1'b1) begin fails++; $display("[TB] FAIL t1_accept: got %0d expected 1", acc); end
    checks++; if (bc != 5) begin fails++; $display("[TB] FAIL t1_busy_cycles: got %0d expected 5", bc); end
    checks++; if (sc != 1 || ops !== 4'hA) begin fails++; $display("[TB] FAIL t1_start: got pulses=%0d op=%0h expected 1/a", sc, ops); end
    checks++; if (wc != 1 || rds !== 5'd5) begin fails++; $display("[TB] FAIL t1_wb: got pulses=%0d rd=%0d expected 1/5", wc, rds); end
    checks++; if (last_lat !== 7'd3) begin fails++; $display("[TB] FAIL t1_last_lat: got %0d expected 3", last_lat); end
  endtask

  task automatic test_hazard();
    in_valid = 1; in_aorf = 1; in_aluop = 4'h3; in_regwrite = 1; in_rdist = 5'd5;
    in_rs = 0; in_rt = 0;
    tick();
    in_valid = 0; in_aorf = 0;
    tick();
    in_valid = 1; in_aorf = 0; in_regwrite = 0; in_rs = 5'd5; in_rt = 5'd1; in_rdist = 5'd0;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t2_raw_rs: got %0d expected 0", in_ready); end
    in_rs = 5'd1; in_rt = 5'd5;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t2_raw_rt: got %0d expected 0", in_ready); end
    in_rs = 5'd1; in_rt = 5'd2; in_regwrite = 1; in_rdist = 5'd5;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t2_waw: got %0d expected 0", in_ready); end
    in_regwrite = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL t2_rd_no_write: got %0d expected 1", in_ready); end
    in_rs = 5'd6; in_rt = 5'd0; in_regwrite = 1; in_rdist = 5'd7;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL t2_indep_int: got %0d expected 1", in_ready); end
    in_rs = 5'd5; in_regwrite = 0; in_rdist = 5'd0; fpu_valid = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t2_wait_stall: got %0d expected 0", in_ready); end
    tick();
    fpu_valid = 0;
    #1;
    checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b1) begin fails++; $display("[TB] FAIL t2_done_stall: got ready=%0d wb=%0d expected 0/1", in_ready, wb_valid); end
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL t2_idle_release: got ready=%0d busy=%0d expected 1/0", in_ready, busy); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    in_valid = 1; in_aorf = 1; in_aluop = 4'h2; in_regwrite = 1; in_rdist = 5'd3;
    in_rs = 0; in_rt = 0;
    tick();
    in_aluop = 4'h5; in_rdist = 5'd9;
    #1;
    checks++; if (in_ready !== 1'b0 || fpu_start !== 1'b1) begin fails++; $display("[TB] FAIL t3_issue: got ready=%0d start=%0d expected 0/1", in_ready, fpu_start); end
    tick();
    checks++; if (in_ready !== 1'b0 || fpu_start !== 1'b0) begin fails++; $display("[TB] FAIL t3_wait0: got ready=%0d start=%0d expected 0/0", in_ready, fpu_start); end
    tick();
    fpu_valid = 1;
    tick();
    fpu_valid = 0;
    #1;
    checks++; if (in_ready !== 1'b0 || wb_rd !== 5'd3 || last_lat !== 7'd2) begin fails++; $display("[TB] FAIL t3_done_a: got ready=%0d rd=%0d lat=%0d expected 0/3/2", in_ready, wb_rd, last_lat); end
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL t3_idle_accept: got ready=%0d busy=%0d expected 1/0", in_ready, busy); end
    tick();
    in_valid = 0; in_aorf = 0;
    #1;
    checks++; if (fpu_start !== 1'b1 || fpu_op !== 4'h5) begin fails++; $display("[TB] FAIL t3_start_b: got start=%0d op=%0h expected 1/5", fpu_start, fpu_op); end
    tick();
    fpu_valid = 1;
    tick();
    fpu_valid = 0;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || last_lat !== 7'd1) begin fails++; $display("[TB] FAIL t3_done_b: got wb=%0d rd=%0d lat=%0d expected 1/9/1", wb_valid, wb_rd, last_lat); end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    int bad = 0;
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL t4_err_before: got %0d expected 0", timeout_err); end
    in_valid = 1; in_aorf = 1; in_aluop = 4'h7; in_regwrite = 1; in_rdist = 5'd4;
    tick();
    in_valid = 0; in_aorf = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (fpu_abort || !busy || wb_valid || timeout_err) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("[TB] FAIL t4_wait_window: got %0d bad cycles expected 0", bad); end
    tick();
    checks++; if (fpu_abort !== 1'b1 || timeout_err !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL t4_abort: got abort=%0d err=%0d busy=%0d expected 1/1/0", fpu_abort, timeout_err, busy); end
    checks++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL t4_no_wb: got %0d expected 0", wb_valid); end
    fpu_valid = 1;
    tick();
    fpu_valid = 0;
    #1;
    checks++; if (fpu_abort !== 1'b0 || timeout_err !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL t4_sticky: got abort=%0d err=%0d busy=%0d wb=%0d expected 0/1/0/0", fpu_abort, timeout_err, busy, wb_valid); end
    tick();
    clear_inputs();
  endtask

  task automatic test_flush();
    logic acc; int bc, sc, wc; logic [4:0] rds; logic [3:0] ops;
    run_fp_op(5'd2, 4'h1, 3, acc, bc, sc, wc, rds, ops);
    checks++; if (last_lat !== 7'd3 || timeout_err !== 1'b1) begin fails++; $display("[TB] FAIL t5_pre: got lat=%0d err=%0d expected 3/1", last_lat, timeout_err); end
    in_valid = 1; in_aorf = 0; flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t5_idle_flush_ready: got %0d expected 0", in_ready); end
    tick();
    flush = 0;
    #1;
    checks++; if (fpu_abort !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL t5_idle_flush_effect: got abort=%0d busy=%0d expected 0/0", fpu_abort, busy); end
    in_aorf = 1; in_aluop = 4'h6; in_regwrite = 1; in_rdist = 5'd6;
    tick();
    in_valid = 0; in_aorf = 0;
    tick();
    fpu_valid = 1; flush = 1;
    #1;
    checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t5_flush_cycle: got wb=%0d ready=%0d expected 0/0", wb_valid, in_ready); end
    tick();
    fpu_valid = 0; flush = 0;
    #1;
    checks++; if (fpu_abort !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL t5_abort: got abort=%0d busy=%0d wb=%0d expected 1/0/0", fpu_abort, busy, wb_valid); end
    checks++; if (last_lat !== 7'd3) begin fails++; $display("[TB] FAIL t5_last_lat: got %0d expected 3", last_lat); end
    tick();
    checks++; if (fpu_abort !== 1'b0 || wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL t5_after: got abort=%0d wb=%0d expected 0/0", fpu_abort, wb_valid); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic acc; int bc, sc, wc; logic [4:0] rds; logic [3:0] ops;
    in_valid = 1; in_aorf = 1; in_aluop = 4'h9; in_regwrite = 1; in_rdist = 5'd5;
    tick();
    in_valid = 0; in_aorf = 0;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL t6_busy_before: got %0d expected 1", busy); end
    reset = 1;
    #1;
    checks++; if (busy !== 1'b0 || fpu_start !== 1'b0 || fpu_abort !== 1'b0 || wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL t6_async_ctrl: got busy=%0d start=%0d abort=%0d wb=%0d expected 0/0/0/0", busy, fpu_start, fpu_abort, wb_valid); end
    checks++; if (timeout_err !== 1'b0 || last_lat !== 7'd0 || fpu_op !== 4'd0 || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t6_async_regs: got err=%0d lat=%0d op=%0d ready=%0d expected 0/0/0/0", timeout_err, last_lat, fpu_op, in_ready); end
    tick();
    checks++; if (fpu_abort !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL t6_held: got abort=%0d busy=%0d expected 0/0", fpu_abort, busy); end
    reset = 0;
    #1;
    run_fp_op(5'd5, 4'hC, 3, acc, bc, sc, wc, rds, ops);
    checks++; if (acc !== 1'b1 || bc != 5 || sc != 1 || ops !== 4'hC) begin fails++; $display("[TB] FAIL t6_rerun_issue: got acc=%0d busy=%0d starts=%0d op=%0h expected 1/5/1/c", acc, bc, sc, ops); end
    checks++; if (wc != 1 || rds !== 5'd5 || last_lat !== 7'd3) begin fails++; $display("[TB] FAIL t6_rerun_wb: got pulses=%0d rd=%0d lat=%0d expected 1/5/3", wc, rds, last_lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hazard();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
